// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer: streams latched operands LSB-first through an external
// 1-bit full adder, recirculates its carry and gathers the sum bits; start-to-done is WIDTH+1 cycles.
module serial_add_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sa_d;
  logic [WIDTH-1:0] sb_d;

  assign sr_d = {fa_sum, sr_q[WIDTH-1:1]};
  assign sa_d = {1'b0, sa_q[WIDTH-1:1]};
  assign sb_d = {1'b0, sb_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= op_a;
            sb_q    <= op_b;
            carry_q <= cin;
            cnt_q   <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sr_q    <= sr_d;
          carry_q <= fa_cout;
          sa_q    <= sa_d;
          sb_q    <= sb_d;
          cnt_q   <= cnt_q + 1'b1;
          // Last bit pair: the adder's current outputs complete the result.
          if (cnt_q == LAST_BIT) begin
            sum_q   <= sr_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Gating with busy_q keeps the adder inputs quiet outside RUN; both terms are flops.
  assign fa_a   = busy_q & sa_q[0];
  assign fa_b   = busy_q & sb_q[0];
  assign fa_cin = busy_q & carry_q;

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
